// File: rtl/ysyx_23060042_exu_mc.sv
// Multi-cycle execute unit: operand select, single-cycle ALU, iterative shift-add
// multiplier and load-data mux, with valid/ready on both sides and ebreak halt capture.
module ysyx_23060042_exu_mc #(
    parameter int XLEN     = 32,
    parameter int ALU_OP_W = 4,
    parameter int MUL_STEP = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [XLEN-1:0]     in_pc,
    input  logic [XLEN-1:0]     in_rdata1,
    input  logic [XLEN-1:0]     in_rdata2,
    input  logic [XLEN-1:0]     in_imm,
    input  logic [XLEN-1:0]     in_a0,
    input  logic [ALU_OP_W-1:0] in_aluop,
    input  logic                in_pcren,
    input  logic                in_src2_sel,
    input  logic [1:0]          in_mren,
    input  logic [XLEN-1:0]     in_mrdata,
    input  logic                in_brken,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [XLEN-1:0]     out_wdata,
    output logic                out_halt,
    output logic [XLEN-1:0]     out_halt_code,
    output logic                halted
);
    localparam int K   = XLEN / MUL_STEP;
    localparam int SHW = $clog2(XLEN);
    localparam int CW  = $clog2(K + 1);

    localparam logic [ALU_OP_W-1:0] OP_ADD   = ALU_OP_W'(0);
    localparam logic [ALU_OP_W-1:0] OP_SUB   = ALU_OP_W'(1);
    localparam logic [ALU_OP_W-1:0] OP_AND   = ALU_OP_W'(2);
    localparam logic [ALU_OP_W-1:0] OP_OR    = ALU_OP_W'(3);
    localparam logic [ALU_OP_W-1:0] OP_XOR   = ALU_OP_W'(4);
    localparam logic [ALU_OP_W-1:0] OP_SLL   = ALU_OP_W'(5);
    localparam logic [ALU_OP_W-1:0] OP_SRL   = ALU_OP_W'(6);
    localparam logic [ALU_OP_W-1:0] OP_SRA   = ALU_OP_W'(7);
    localparam logic [ALU_OP_W-1:0] OP_SLT   = ALU_OP_W'(8);
    localparam logic [ALU_OP_W-1:0] OP_SLTU  = ALU_OP_W'(9);
    localparam logic [ALU_OP_W-1:0] OP_MUL   = ALU_OP_W'(10);
    localparam logic [ALU_OP_W-1:0] OP_MULHU = ALU_OP_W'(11);

    typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

    state_t              state, state_nx;
    logic [XLEN-1:0]     src1, src2, alu_res;
    logic [SHW-1:0]      shamt;
    logic [2*XLEN-1:0]   acc, acc_nx, mcand, pp;
    logic [XLEN-1:0]     mplier;
    logic [MUL_STEP-1:0] digit;
    logic [CW-1:0]       cnt;
    logic                mul_hi, is_load, is_mul, accept;

    assign src1    = in_pcren ? in_pc : in_rdata1;
    assign src2    = in_src2_sel ? in_rdata2 : in_imm;
    assign shamt   = src2[SHW-1:0];
    assign is_load = (in_mren != 2'b00);
    // ebreak and loads always take the single-cycle path, even with a multiply op code
    assign is_mul  = !is_load && !in_brken && (in_aluop == OP_MUL || in_aluop == OP_MULHU);

    always_comb begin
        alu_res = '0;
        case (in_aluop)
            OP_ADD:  alu_res = src1 + src2;
            OP_SUB:  alu_res = src1 - src2;
            OP_AND:  alu_res = src1 & src2;
            OP_OR:   alu_res = src1 | src2;
            OP_XOR:  alu_res = src1 ^ src2;
            OP_SLL:  alu_res = src1 << shamt;
            OP_SRL:  alu_res = src1 >> shamt;
            OP_SRA:  alu_res = $unsigned($signed(src1) >>> shamt);
            OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(src1) < $signed(src2)};
            OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, src1 < src2};
            default: alu_res = '0;
        endcase
    end

    // One radix-2^MUL_STEP digit per cycle; the multiplicand walks left instead of shifting the sum
    assign digit  = mplier[MUL_STEP-1:0];
    assign pp     = mcand * {{(2*XLEN-MUL_STEP){1'b0}}, digit};
    assign acc_nx = acc + pp;

    assign out_valid = (state == DONE);
    assign in_ready  = !halted && ((state == IDLE) ||
                                   (state == DONE && out_ready && !out_halt));
    assign accept    = in_valid && in_ready;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = IDLE;
            MUL:     if (cnt == CW'(1)) state_nx = DONE;
            DONE:    if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (accept) state_nx = is_mul ? MUL : DONE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            out_wdata     <= '0;
            out_halt      <= 1'b0;
            out_halt_code <= '0;
            halted        <= 1'b0;
            cnt           <= '0;
            acc           <= '0;
            mcand         <= '0;
            mplier        <= '0;
            mul_hi        <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == DONE && out_ready && out_halt)
                halted <= 1'b1;
            if (accept) begin
                if (is_mul) begin
                    acc      <= '0;
                    mcand    <= {{XLEN{1'b0}}, src1};
                    mplier   <= src2;
                    cnt      <= CW'(K);
                    mul_hi   <= (in_aluop == OP_MULHU);
                    out_halt <= 1'b0;
                end else begin
                    out_wdata <= is_load ? in_mrdata : alu_res;
                    out_halt  <= in_brken;
                    if (in_brken)
                        out_halt_code <= in_a0;
                end
            end else if (state == MUL) begin
                acc    <= acc_nx;
                mcand  <= mcand << MUL_STEP;
                mplier <= mplier >> MUL_STEP;
                cnt    <= cnt - CW'(1);
                if (cnt == CW'(1))
                    out_wdata <= mul_hi ? acc_nx[2*XLEN-1:XLEN] : acc_nx[XLEN-1:0];
            end
        end
    end
endmodule
